uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised RS-232 UART receiver; successor to the fixed 8N1 receiver. Adds configurable
//  data width, parity and stop bits, a 2-flop rx synchroniser, 3-sample majority vote, false-start
//  rejection, error flags and a valid/ready output handshake with overrun detection.
//  Sits between the rx pad and a byte consumer (FIFO or command parser).
// PARAMETERS
//  DIVIDER    104  clock cycles per bit (12 MHz/104 = 115200 baud); legal >= 8
//  DATA_BITS  8    data bits per frame, 5..9, LSB first
//  PARITY     0    0 = none, 1 = odd, 2 = even
//  STOP_BITS  1    1 or 2
// PORTS
//  clock         in   1          system clock
//  reset_n       in   1          synchronous, active-low reset
//  rx            in   1          asynchronous serial line, idle high
//  rx_data       out  DATA_BITS  received word; stable while rx_valid=1
//  rx_valid      out  1          word available; held until accepted
//  rx_ready      in   1          consumer accepts word when rx_valid & rx_ready
//  parity_error  out  1          parity mismatch on word in rx_data; qualified by rx_valid
//  frame_error   out  1          a stop bit sampled low on word in rx_data; qualified by rx_valid
//  overrun       out  1          one-cycle pulse: completed frame dropped, rx_valid still high
//  busy          out  1          high from start-bit detect until return to IDLE
// BEHAVIOUR
//  Reset (reset_n=0 at clock edge): state IDLE, all outputs 0, synchroniser regs = 1.
//   Reset mid-frame aborts the frame; no partial word is ever delivered.
//  rx passes 2 flops (rx_s); all decisions use rx_s. Adds 2 cycles of input latency.
//  Bit counter: 0..DIVIDER-1, width $clog2(DIVIDER). Mid-bit H = DIVIDER/2 (integer division).
//   Samples taken at counts H-1, H, H+1; bit value = majority of the 3, decided at H+1.
//  FSM:
//   IDLE   : rx_s=0 -> START, counter=0, busy=1.
//   START  : vote at mid-bit; 1 -> IDLE (false start, nothing reported); 0 -> DATA.
//   DATA   : DATA_BITS votes, shifted in LSB first; last -> PARITY (PARITY!=0) else STOP.
//   PARITY : vote compared to odd/even parity of data bits -> parity_err_q.
//   STOP   : STOP_BITS votes; any 0 sets frame_err_q. After final stop vote: DELIVER.
//   DELIVER: one cycle; load outputs (below). Last stop vote 1 -> IDLE; 0 -> BREAK.
//   BREAK  : wait for rx_s=1, then IDLE (no re-arm on a held-low line).
//   busy=0 only in IDLE.
//  Delivery in DELIVER cycle, i.e. 1 clock after the final stop vote:
//   rx_valid=0, or rx_valid=1 & rx_ready=1 same cycle: rx_data, parity_error, frame_error
//    loaded, rx_valid=1 (stays 1 on simultaneous accept+load; no bubble).
//   rx_valid=1 & rx_ready=0: new word dropped, old word/flags unchanged, overrun=1 one cycle.
//  Words with parity/frame errors are delivered (not dropped); flags travel with the word.
//  Accept (rx_valid & rx_ready, no load same cycle) -> rx_valid=0 next cycle;
//   rx_data and flags hold their last values.
//  rx_ready is ignored while rx_valid=0.
//  Single glitch of < 1 sample-cycle width at mid-bit is rejected by the vote.
//  Next start bit is detectable from the cycle after DELIVER (half-stop-bit resync margin).
// TESTING (DIVIDER=16 unless noted; "frame" = ideal bit timing at 16 clk/bit)
//  1 8N1, rx_ready=1: send 0xA5 -> one rx_valid cycle, rx_data=0xA5, both error flags 0,
//    rx_valid rises 1 clk after mid-stop vote.
//  2 8E1: send 0x03, parity 0 -> valid, parity_error=0; send 0x03, parity 1 ->
//    parity_error=1, rx_data=0x03.
//  3 Start pulse low for 4 clk, then high -> no rx_valid, busy returns 0 by mid-start+2;
//    a following 0x5A frame is received correctly.
//  4 rx_ready=0: send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once at 2nd DELIVER;
//    raise rx_ready -> rx_valid drops next cycle.
//  5 Break: hold rx low 20 bit times -> word 0x00 with frame_error=1, busy stays 1 until rx high,
//    no further words.
//  6 Assert reset_n=0 during bit 3 of 0xFF, release -> no rx_valid; then 0x81 received cleanly;
//    also run DATA_BITS=7, STOP_BITS=2, PARITY=1 with 0x7F.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised RS-232 receiver: 2-flop synchroniser, 3-sample mid-bit majority vote,
// optional parity, 1/2 stop bits, and a valid/ready output with overrun reporting.
module uart_rx_param #(
  parameter int DIVIDER   = 104,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int            CW        = $clog2(DIVIDER);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIVIDER - 1);
  localparam logic [CW-1:0] SMP_A     = CW'(DIVIDER / 2 - 1);
  localparam logic [CW-1:0] SMP_B     = CW'(DIVIDER / 2);
  localparam logic [CW-1:0] SMP_VOTE  = CW'(DIVIDER / 2 + 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_PAR     = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_DELIVER = 3'd5;
  localparam logic [2:0] S_BREAK   = 3'd6;

  logic                 rx_m, rx_s;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic                 smp0, smp1;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_q, frm_err_q, last_stop;
  logic                 vote, at_vote, counting, par_exp;

  assign vote     = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
  assign counting = (state == S_START) || (state == S_DATA) ||
                    (state == S_PAR)   || (state == S_STOP);
  assign at_vote  = counting && (cnt == SMP_VOTE);
  assign par_exp  = PAR_ODD ? ~^shreg : ^shreg;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_m         <= 1'b1;
      rx_s         <= 1'b1;
      state        <= S_IDLE;
      cnt          <= '0;
      smp0         <= 1'b1;
      smp1         <= 1'b1;
      bit_idx      <= '0;
      shreg        <= '0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      last_stop    <= 1'b1;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (counting) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        if (cnt == SMP_A) smp0 <= rx_s;
        if (cnt == SMP_B) smp1 <= rx_s;
      end

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state     <= S_START;
            cnt       <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
          end
        end
        S_START: begin
          if (at_vote) begin
            state   <= vote ? S_IDLE : S_DATA;
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (at_vote) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_DATA) begin
              state   <= (PARITY != 0) ? S_PAR : S_STOP;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_PAR: begin
          if (at_vote) begin
            par_err_q <= vote ^ par_exp;
            state     <= S_STOP;
            bit_idx   <= '0;
          end
        end
        S_STOP: begin
          if (at_vote) begin
            if (!vote) frm_err_q <= 1'b1;
            if (bit_idx == LAST_STOP) begin
              state     <= S_DELIVER;
              last_stop <= vote;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_DELIVER: begin
          // A same-cycle accept frees the slot, so the new word loads without a bubble.
          if (!rx_valid || rx_ready) begin
            rx_data      <= shreg;
            parity_error <= par_err_q;
            frame_error  <= frm_err_q;
            rx_valid     <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          state <= last_stop ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 8E1, 7O2) at 16 clk/bit, each on its own rx line,
// checked against a frame-level model of word contents, error flags and delivery time.
module tb_uart_rx_param;

  localparam int D = 16;
  localparam int H = D / 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] rx_l;
  logic [2:0] rdy;
  logic [2:0] vld, pe, fe, ovr, bsy;
  logic [7:0] d0, d1;
  logic [6:0] d2;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int         idx;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    int         cyc;
  } word_t;

  word_t q[$];
  int    ovr_cnt[3];
  int    ovr_cyc[3];
  logic [2:0] pv = '0;
  logic [2:0] pr = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.DIVIDER(D), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clock(clk), .reset_n(reset_n), .rx(rx_l[0]), .rx_data(d0), .rx_valid(vld[0]),
    .rx_ready(rdy[0]), .parity_error(pe[0]), .frame_error(fe[0]), .overrun(ovr[0]), .busy(bsy[0]));

  uart_rx_param #(.DIVIDER(D), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clock(clk), .reset_n(reset_n), .rx(rx_l[1]), .rx_data(d1), .rx_valid(vld[1]),
    .rx_ready(rdy[1]), .parity_error(pe[1]), .frame_error(fe[1]), .overrun(ovr[1]), .busy(bsy[1]));

  uart_rx_param #(.DIVIDER(D), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clock(clk), .reset_n(reset_n), .rx(rx_l[2]), .rx_data(d2), .rx_valid(vld[2]),
    .rx_ready(rdy[2]), .parity_error(pe[2]), .frame_error(fe[2]), .overrun(ovr[2]), .busy(bsy[2]));

  function automatic logic [8:0] dsel(input int i);
    if (i == 0) return {1'b0, d0};
    if (i == 1) return {1'b0, d1};
    return {2'b00, d2};
  endfunction

  // A new word is visible when valid rises or stays high right after an accept.
  initial begin
    ovr_cnt = '{0, 0, 0};
    ovr_cyc = '{0, 0, 0};
  end
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && (!pv[i] || pr[i])) q.push_back('{i, dsel(i), pe[i], fe[i], cyc});
      if (ovr[i]) begin
        ovr_cnt[i] <= ovr_cnt[i] + 1;
        ovr_cyc[i] <= cyc;
      end
    end
    pv <= vld;
    pr <= rdy;
  end

  // Delivery edge after the start bit is driven: 2 sync flops, detect, counter start,
  // vote at mid-bit+1 of the final stop bit, then one DELIVER cycle.
  function automatic int lat(input int nbits, input int npar, input int nstop);
    return 6 + H + (nbits + npar + nstop) * D;
  endfunction

  task automatic send_frame(input int idx, input int nbits, input logic [8:0] data,
                            input int par_mode, input logic par_flip,
                            input logic [1:0] stops, input int nstop, output int k);
    logic bits[$];
    int   ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (par_mode == 1) bits.push_back(((ones % 2) == 0) ^ par_flip);
    if (par_mode == 2) bits.push_back(((ones % 2) == 1) ^ par_flip);
    for (int i = 0; i < nstop; i++) bits.push_back(stops[i]);
    @(posedge clk); #1;
    k = cyc;
    foreach (bits[i]) begin
      rx_l[idx] = bits[i];
      repeat (D) @(posedge clk);
      #1;
    end
    rx_l[idx] = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    rx_l = '1;
    rdy = 3'b110;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({vld, pe, fe, ovr, bsy, d0, d1, d2} !== '0)
      $display("FAIL reset_outputs: got %h required 0", {vld, pe, fe, ovr, bsy, d0, d1, d2});
    else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({vld, ovr, bsy} !== '0)
      $display("FAIL reset_release: got %h required 0", {vld, ovr, bsy});
    else n_pass++;
  endtask

  task automatic test_8n1;
    int k;
    logic [8:0] data;
    word_t w;
    rdy[0] = 1'b1;
    q.delete();
    for (int n = 0; n < 6; n++) begin
      data = (n == 0) ? 9'h0A5 : 9'($urandom_range(0, 255));
      send_frame(0, 8, data, 0, 1'b0, 2'b11, 1, k);
      repeat (2) @(negedge clk);
      n_checks++;
      if (q.size() != 1 || vld[0] !== 1'b0) begin
        $display("FAIL 8n1_count: got %0d words valid=%b required 1 word valid=0", q.size(), vld[0]);
        q.delete();
      end else begin
        n_pass++;
        w = q.pop_front();
        n_checks++;
        if ({w.data, w.pe, w.fe} !== {data, 2'b00})
          $display("FAIL 8n1_word: got %h pe=%b fe=%b required %h pe=0 fe=0", w.data, w.pe, w.fe, data);
        else n_pass++;
        n_checks++;
        if (w.cyc != k + lat(8, 0, 1))
          $display("FAIL 8n1_latency: got cycle %0d required %0d", w.cyc - k, lat(8, 0, 1));
        else n_pass++;
      end
    end
  endtask

  task automatic test_parity_8e1;
    int k;
    logic [8:0] data;
    logic flip;
    word_t w;
    q.delete();
    for (int n = 0; n < 6; n++) begin
      data = (n < 2) ? 9'h003 : 9'($urandom_range(0, 255));
      flip = (n < 2) ? n[0] : 1'($urandom_range(0, 1));
      send_frame(1, 8, data, 2, flip, 2'b11, 1, k);
      repeat (2) @(negedge clk);
      n_checks++;
      if (q.size() != 1) begin
        $display("FAIL 8e1_count: got %0d words required 1", q.size());
        q.delete();
      end else begin
        n_pass++;
        w = q.pop_front();
        n_checks++;
        if ({w.data, w.pe, w.fe, w.cyc - k} !== {data, flip, 1'b0, lat(8, 1, 1)})
          $display("FAIL 8e1_word: got %h pe=%b fe=%b lat=%0d required %h pe=%b fe=0 lat=%0d",
                   w.data, w.pe, w.fe, w.cyc - k, data, flip, lat(8, 1, 1));
        else n_pass++;
      end
    end
  endtask

  task automatic test_false_start;
    int k;
    word_t w;
    q.delete();
    @(posedge clk); #1;
    k = cyc;
    rx_l[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_l[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bsy[0] !== 1'b1) $display("FAIL false_start_busy: got %b required 1", bsy[0]);
    else n_pass++;
    while (cyc < k + H + 6) @(negedge clk);
    n_checks++;
    if (bsy[0] !== 1'b0 || q.size() != 0)
      $display("FAIL false_start_reject: got busy=%b words=%0d required busy=0 words=0", bsy[0], q.size());
    else n_pass++;
    send_frame(0, 8, 9'h05A, 0, 1'b0, 2'b11, 1, k);
    repeat (2) @(negedge clk);
    n_checks++;
    if (q.size() != 1) begin
      $display("FAIL false_start_next_count: got %0d words required 1", q.size());
    end else begin
      n_pass++;
      w = q.pop_front();
      n_checks++;
      if ({w.data, w.pe, w.fe} !== {9'h05A, 2'b00})
        $display("FAIL false_start_next_word: got %h required 05a", w.data);
      else n_pass++;
    end
  endtask

  task automatic test_overrun;
    int k1, k2, ov0;
    q.delete();
    rdy[0] = 1'b0;
    ov0 = ovr_cnt[0];
    send_frame(0, 8, 9'h011, 0, 1'b0, 2'b11, 1, k1);
    repeat (2) @(negedge clk);
    send_frame(0, 8, 9'h022, 0, 1'b0, 2'b11, 1, k2);
    repeat (2) @(negedge clk);
    n_checks++;
    if (q.size() != 1 || {vld[0], d0} !== {1'b1, 8'h11})
      $display("FAIL overrun_hold: got words=%0d valid=%b data=%h required 1/1/11", q.size(), vld[0], d0);
    else n_pass++;
    n_checks++;
    if (ovr_cnt[0] - ov0 != 1 || ovr_cyc[0] != k2 + lat(8, 0, 1))
      $display("FAIL overrun_pulse: got count=%0d at %0d required 1 at %0d",
               ovr_cnt[0] - ov0, ovr_cyc[0] - k2, lat(8, 0, 1));
    else n_pass++;
    @(posedge clk); #1;
    rdy[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({vld[0], d0} !== {1'b0, 8'h11})
      $display("FAIL overrun_accept: got valid=%b data=%h required 0/11", vld[0], d0);
    else n_pass++;
    q.delete();
  endtask

  task automatic test_break;
    word_t w;
    q.delete();
    @(posedge clk); #1;
    rx_l[0] = 1'b0;
    repeat (20 * D) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 1 || bsy[0] !== 1'b1) begin
      $display("FAIL break_word_count: got words=%0d busy=%b required 1/1", q.size(), bsy[0]);
    end else begin
      n_pass++;
      w = q.pop_front();
      n_checks++;
      if ({w.data, w.pe, w.fe} !== {9'h000, 2'b01})
        $display("FAIL break_word: got %h pe=%b fe=%b required 000 pe=0 fe=1", w.data, w.pe, w.fe);
      else n_pass++;
    end
    @(posedge clk); #1;
    rx_l[0] = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (bsy[0] !== 1'b0) $display("FAIL break_release: got busy=%b required 0", bsy[0]);
    else n_pass++;
    repeat (2 * D) @(negedge clk);
    n_checks++;
    if (q.size() != 0) $display("FAIL break_extra: got %0d extra words required 0", q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int k;
    word_t w;
    q.delete();
    @(posedge clk); #1;
    rx_l[0] = 1'b0;
    repeat (D) @(posedge clk);
    #1 rx_l[0] = 1'b1;
    repeat (3 * D + H) @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8 * D) @(negedge clk);
    n_checks++;
    if (q.size() != 0 || {vld[0], bsy[0]} !== 2'b00)
      $display("FAIL reset_mid_abort: got words=%0d valid=%b busy=%b required 0/0/0", q.size(), vld[0], bsy[0]);
    else n_pass++;
    q.delete();
    send_frame(0, 8, 9'h081, 0, 1'b0, 2'b11, 1, k);
    repeat (2) @(negedge clk);
    n_checks++;
    if (q.size() != 1) begin
      $display("FAIL reset_mid_next_count: got %0d words required 1", q.size());
    end else begin
      n_pass++;
      w = q.pop_front();
      n_checks++;
      if ({w.data, w.pe, w.fe} !== {9'h081, 2'b00})
        $display("FAIL reset_mid_next_word: got %h required 081", w.data);
      else n_pass++;
    end
  endtask

  task automatic test_7o2;
    int k;
    logic [8:0] data;
    logic flip;
    logic [1:0] stops;
    word_t w;
    q.delete();
    for (int n = 0; n < 6; n++) begin
      data  = (n == 0) ? 9'h07F : 9'($urandom_range(0, 127));
      flip  = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      stops = (n == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      send_frame(2, 7, data, 1, flip, stops, 2, k);
      repeat (D) @(negedge clk);
      n_checks++;
      if (q.size() != 1) begin
        $display("FAIL 7o2_count: got %0d words required 1", q.size());
        q.delete();
      end else begin
        n_pass++;
        w = q.pop_front();
        n_checks++;
        if ({w.data, w.pe, w.fe, w.cyc - k} !== {data, flip, stops != 2'b11, lat(7, 1, 2)})
          $display("FAIL 7o2_word: got %h pe=%b fe=%b lat=%0d required %h pe=%b fe=%b lat=%0d",
                   w.data, w.pe, w.fe, w.cyc - k, data, flip, stops != 2'b11, lat(7, 1, 2));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity_8e1();
    test_false_start();
    test_overrun();
    test_break();
    test_reset_mid();
    test_7o2();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
